fetch_stage: RTL

Instruction fetch stage plus the IF/ID pipeline register, directly upstream of the hazard detection unit and the decode/control logic. Owns the PC and runs a req/ack handshake with instruction memory. Consumes pc_write/stall from hazard detection and taken/branch_target from branch resolution. Produces the IF/ID instruction, PC and valid bit that decode reads to generate regRead0/regRead1.

---
 rtl/fetch_stage.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC, imem req/ack handshake and IF/ID pipeline register.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module fetch_stage #(
  parameter int unsigned            PC_W      = 16,
  parameter int unsigned            INSTR_W   = 32,
  parameter logic [PC_W-1:0]        RESET_PC  = '0,
  parameter logic [PC_W-1:0]        PC_STEP   = PC_W'(4),
  parameter logic [INSTR_W-1:0]     NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_write,
  input  logic               stall,
  input  logic               taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count,
`endif
  output logic               fetch_busy
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t             r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_hold_buf;
  logic               r_redirect_pending;
  logic [PC_W-1:0]    r_redirect_target;
  logic               r_req_en;
  logic [INSTR_W-1:0] r_if_id_instr;
  logic [PC_W-1:0]    r_if_id_pc;
  logic               r_if_id_valid;

  state_t             w_state_next;
  logic [PC_W-1:0]    w_pc_next;
  logic [INSTR_W-1:0] w_hold_buf_next;
  logic               w_redirect_pending_next;
  logic [PC_W-1:0]    w_redirect_target_next;
  logic [INSTR_W-1:0] w_if_id_instr_next;
  logic [PC_W-1:0]    w_if_id_pc_next;
  logic               w_if_id_valid_next;

  logic w_advance;
  logic w_req;
  logic w_ack;

  assign w_advance = pc_write & ~stall;
  // r_req_en keeps the request low for the first cycle after reset release.
  assign w_req     = r_req_en & (r_state == S_FETCH);
  assign w_ack     = imem_ack & w_req;

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_valid = r_if_id_valid;
  assign fetch_busy  = (w_req & ~imem_ack) | r_redirect_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= S_FETCH;
      r_pc               <= RESET_PC;
      r_hold_buf         <= '0;
      r_redirect_pending <= 1'b0;
      r_redirect_target  <= '0;
      r_req_en           <= 1'b0;
      r_if_id_instr      <= NOP_INSTR;
      r_if_id_pc         <= '0;
      r_if_id_valid      <= 1'b0;
    end else begin
      r_state            <= w_state_next;
      r_pc               <= w_pc_next;
      r_hold_buf         <= w_hold_buf_next;
      r_redirect_pending <= w_redirect_pending_next;
      r_redirect_target  <= w_redirect_target_next;
      r_req_en           <= 1'b1;
      r_if_id_instr      <= w_if_id_instr_next;
      r_if_id_pc         <= w_if_id_pc_next;
      r_if_id_valid      <= w_if_id_valid_next;
    end
  end

  always_comb begin
    w_state_next            = r_state;
    w_pc_next               = r_pc;
    w_hold_buf_next         = r_hold_buf;
    w_redirect_pending_next = r_redirect_pending;
    w_redirect_target_next  = r_redirect_target;
    w_if_id_instr_next      = r_if_id_instr;
    w_if_id_pc_next         = r_if_id_pc;
    w_if_id_valid_next      = r_if_id_valid;

    if (taken) begin
      w_if_id_instr_next = NOP_INSTR;
      w_if_id_valid_next = 1'b0;
      if (r_state == S_HOLD) begin
        w_pc_next    = branch_target;
        w_state_next = S_FETCH;
      end else if (w_ack || !r_req_en) begin
        // Nothing left in flight: redirect immediately.
        w_pc_next               = branch_target;
        w_redirect_pending_next = 1'b0;
      end else begin
        // Request still outstanding; its response must be thrown away first.
        w_redirect_target_next  = branch_target;
        w_redirect_pending_next = 1'b1;
      end
    end else if (r_state == S_FETCH) begin
      if (w_ack && r_redirect_pending) begin
        w_pc_next               = r_redirect_target;
        w_redirect_pending_next = 1'b0;
        if (!stall) begin
          w_if_id_instr_next = NOP_INSTR;
          w_if_id_valid_next = 1'b0;
        end
      end else if (w_ack && w_advance) begin
        w_if_id_instr_next = imem_rdata;
        w_if_id_pc_next    = r_pc;
        w_if_id_valid_next = 1'b1;
        w_pc_next          = r_pc + PC_STEP;
      end else if (w_ack) begin
        w_hold_buf_next = imem_rdata;
        w_state_next    = S_HOLD;
      end else if (!stall) begin
        w_if_id_instr_next = NOP_INSTR;
        w_if_id_valid_next = 1'b0;
      end
    end else begin
      if (w_advance) begin
        w_if_id_instr_next = r_hold_buf;
        w_if_id_pc_next    = r_pc;
        w_if_id_valid_next = 1'b1;
        w_pc_next          = r_pc + PC_STEP;
        w_state_next       = S_FETCH;
      end else if (!stall) begin
        w_if_id_instr_next = NOP_INSTR;
        w_if_id_valid_next = 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

  // Both counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!w_advance && r_if_id_valid && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (taken && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end
`endif

endmodule
